// File: rtl/mem_read_router.sv
// Memory read-return router.
// Tags each issued read with its owner and load format, then steers the in-order
// read returns either into a small instruction queue (fetch) or onto a registered
// register-file write port after byte alignment and sign/zero extension (load).
module mem_read_router #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 16,
    parameter int TAG_DEPTH   = 2,
    parameter int IQ_DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   read_issue_in,
    input  logic                   read_en_sel_in,
    input  logic                   word_select_in,
    input  logic [1:0]             addr_lsb_in,
    input  logic [1:0]             load_size_in,
    input  logic                   load_signed_in,
    input  logic [3:0]             load_dest_in,
    input  logic                   flush_in,
    input  logic [DATA_WIDTH-1:0]  mem_data_in,
    input  logic                   mem_output_valid_in,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid_out,
    input  logic                   instr_ready_in,
    output logic                   tag_full_out,
    output logic                   iq_full_out,
    output logic                   load_wr_en_out,
    output logic [3:0]             load_wr_addr_out,
    output logic [DATA_WIDTH-1:0]  load_wr_data_out,
    output logic                   error_out
);
    localparam int TPW   = $clog2(TAG_DEPTH);
    localparam int IPW   = $clog2(IQ_DEPTH);
    // Tag layout: {owner, word_select, addr_lsb[1:0], size[1:0], signed, dest[3:0]}
    localparam int TAG_W = 11;
    localparam int T_OWN = 10;

    // Tag FIFO: payload in a plain array, discard bits kept in resettable flops
    // because a flush rewrites every entry at once.
    logic [TAG_W-1:0]     tag_mem_q [TAG_DEPTH];
    logic [TAG_DEPTH-1:0] tag_disc_q, tag_disc_d;
    logic [TPW-1:0]       tag_wr_q, tag_rd_q;
    logic [TPW:0]         tag_cnt_q, tag_cnt_d;
    // Non-discarded fetch tags still in flight; they each reserve an IQ slot.
    logic [TPW:0]         fetch_pend_q, fetch_pend_d;

    logic [INSTR_WIDTH-1:0] iq_mem_q [IQ_DEPTH];
    logic [IPW-1:0]         iq_wr_q, iq_rd_q;
    logic [IPW:0]           iq_cnt_q;

    logic                   error_q, load_wr_en_q;
    logic [3:0]             load_wr_addr_q;
    logic [DATA_WIDTH-1:0]  load_wr_data_q;

    logic                   ret_pop, ret_orphan, tag_push, head_disc;
    logic [TAG_W-1:0]       head_tag;
    logic                   fetch_ret, load_ret, fetch_keep;
    logic                   iq_deq, iq_is_full, iq_push, iq_ovf;
    logic [INSTR_WIDTH-1:0] fetch_data;
    logic [DATA_WIDTH-1:0]  shifted, load_data;

    assign tag_full_out = (tag_cnt_q == (TPW+1)'(TAG_DEPTH));
    assign ret_pop      = mem_output_valid_in && (tag_cnt_q != '0);
    assign ret_orphan   = mem_output_valid_in && (tag_cnt_q == '0);
    // A return in the same cycle frees a slot, so issue is accepted even when full.
    assign tag_push     = read_issue_in && (!tag_full_out || ret_pop);
    assign head_tag     = tag_mem_q[tag_rd_q];
    assign head_disc    = tag_disc_q[tag_rd_q];
    assign fetch_ret    = ret_pop && head_tag[T_OWN];
    assign load_ret     = ret_pop && !head_tag[T_OWN];
    // Fetch data returning during a flush belongs to the old stream.
    assign fetch_keep   = fetch_ret && !head_disc && !flush_in;

    assign iq_deq       = (iq_cnt_q != '0) && instr_ready_in;
    assign iq_is_full   = (iq_cnt_q == (IPW+1)'(IQ_DEPTH));
    assign iq_push      = fetch_keep && (!iq_is_full || iq_deq);
    assign iq_ovf       = fetch_keep && iq_is_full && !iq_deq;
    assign fetch_data   = head_tag[9] ? mem_data_in[DATA_WIDTH-1 -: INSTR_WIDTH]
                                      : mem_data_in[INSTR_WIDTH-1:0];

    assign instr_valid_out  = (iq_cnt_q != '0);
    assign instr_out        = instr_valid_out ? iq_mem_q[iq_rd_q] : '0;
    assign iq_full_out      = (32'(iq_cnt_q) + 32'(fetch_pend_q)) >= 32'(IQ_DEPTH);
    assign load_wr_en_out   = load_wr_en_q;
    assign load_wr_addr_out = load_wr_addr_q;
    assign load_wr_data_out = load_wr_data_q;
    assign error_out        = error_q;

    // Discard bit per tag entry: a new push clears it, a flush marks fetch entries.
    genvar gi;
    generate
        for (gi = 0; gi < TAG_DEPTH; gi++) begin : g_disc
            assign tag_disc_d[gi] = (tag_push && (tag_wr_q == TPW'(gi))) ? 1'b0 :
                                    (flush_in && tag_mem_q[gi][T_OWN])    ? 1'b1 :
                                    tag_disc_q[gi];
        end
    endgenerate

    // Occupancy counters for the tag FIFO and the pending-fetch reservation.
    always_comb begin
        tag_cnt_d = tag_cnt_q;
        case ({tag_push, ret_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase
        fetch_pend_d = fetch_pend_q;
        if (flush_in) begin
            fetch_pend_d = (tag_push && read_en_sel_in) ? (TPW+1)'(1) : '0;
        end else begin
            if (tag_push && read_en_sel_in)
                fetch_pend_d = fetch_pend_d + 1'b1;
            if (fetch_ret && !head_disc)
                fetch_pend_d = fetch_pend_d - 1'b1;
        end
    end

    // Load alignment: shift the addressed byte down, then mask and extend by size.
    always_comb begin
        shifted   = mem_data_in >> {addr_lsb_in_tag(head_tag), 3'b000};
        load_data = mem_data_in;
        case (head_tag[6:5])
            2'b00:   load_data = {{(DATA_WIDTH-8){head_tag[4] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(DATA_WIDTH-16){head_tag[4] & shifted[15]}}, shifted[15:0]};
            default: load_data = mem_data_in;
        endcase
    end

    function automatic logic [1:0] addr_lsb_in_tag(input logic [TAG_W-1:0] t);
        return t[8:7];
    endfunction

    // Payload storage for tags and queued instructions (no reset needed).
    always_ff @(posedge clk) begin
        if (tag_push)
            tag_mem_q[tag_wr_q] <= {read_en_sel_in, word_select_in, addr_lsb_in,
                                    load_size_in, load_signed_in, load_dest_in};
        if (iq_push)
            iq_mem_q[iq_wr_q] <= fetch_data;
    end

    // Control state: pointers, counts, load write port and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_wr_q       <= '0;
            tag_rd_q       <= '0;
            tag_cnt_q      <= '0;
            tag_disc_q     <= '0;
            fetch_pend_q   <= '0;
            iq_wr_q        <= '0;
            iq_rd_q        <= '0;
            iq_cnt_q       <= '0;
            error_q        <= 1'b0;
            load_wr_en_q   <= 1'b0;
            load_wr_addr_q <= '0;
            load_wr_data_q <= '0;
        end else begin
            if (tag_push) tag_wr_q <= tag_wr_q + 1'b1;
            if (ret_pop)  tag_rd_q <= tag_rd_q + 1'b1;
            tag_cnt_q    <= tag_cnt_d;
            tag_disc_q   <= tag_disc_d;
            fetch_pend_q <= fetch_pend_d;

            if (flush_in) begin
                iq_wr_q  <= '0;
                iq_rd_q  <= '0;
                iq_cnt_q <= '0;
            end else begin
                if (iq_push) iq_wr_q <= iq_wr_q + 1'b1;
                if (iq_deq)  iq_rd_q <= iq_rd_q + 1'b1;
                if (iq_push && !iq_deq)      iq_cnt_q <= iq_cnt_q + 1'b1;
                else if (!iq_push && iq_deq) iq_cnt_q <= iq_cnt_q - 1'b1;
            end

            load_wr_en_q <= load_ret;
            if (load_ret) begin
                load_wr_addr_q <= head_tag[3:0];
                load_wr_data_q <= load_data;
            end

            if (ret_orphan || iq_ovf)
                error_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_read_router.sv
// Bench for mem_read_router: directed scenarios plus a randomized run checked
// against a queue-based model of tags and the instruction queue.
module tb_mem_read_router;
    localparam int IQD = 2;
    localparam int TGD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_issue_in, read_en_sel_in, word_select_in;
    logic [1:0]  addr_lsb_in, load_size_in;
    logic        load_signed_in;
    logic [3:0]  load_dest_in;
    logic        flush_in;
    logic [31:0] mem_data_in;
    logic        mem_output_valid_in;
    logic [15:0] instr_out;
    logic        instr_valid_out, instr_ready_in;
    logic        tag_full_out, iq_full_out;
    logic        load_wr_en_out;
    logic [3:0]  load_wr_addr_out;
    logic [31:0] load_wr_data_out;
    logic        error_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_read_router dut (
        .clk(clk), .reset(reset),
        .read_issue_in(read_issue_in), .read_en_sel_in(read_en_sel_in),
        .word_select_in(word_select_in), .addr_lsb_in(addr_lsb_in),
        .load_size_in(load_size_in), .load_signed_in(load_signed_in),
        .load_dest_in(load_dest_in), .flush_in(flush_in),
        .mem_data_in(mem_data_in), .mem_output_valid_in(mem_output_valid_in),
        .instr_out(instr_out), .instr_valid_out(instr_valid_out),
        .instr_ready_in(instr_ready_in), .tag_full_out(tag_full_out),
        .iq_full_out(iq_full_out), .load_wr_en_out(load_wr_en_out),
        .load_wr_addr_out(load_wr_addr_out), .load_wr_data_out(load_wr_data_out),
        .error_out(error_out)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       owner;
        bit       ws;
        bit [1:0] lsb;
        bit [1:0] size;
        bit       sgn;
        bit [3:0] dest;
        bit       disc;
    } tag_t;

    tag_t        tq[$];
    logic [15:0] iq[$];
    bit          m_err;
    bit          m_wr_en;
    logic [3:0]  m_wr_addr;
    logic [31:0] m_wr_data;

    function automatic logic [31:0] load_value(logic [31:0] d, bit [1:0] lsb, bit [1:0] size, bit sgn);
        int unsigned sh;
        int unsigned v;
        if (size >= 2) return d;
        sh = d / (32'd1 << (8 * lsb));
        if (size == 0) begin
            v = sh % 256;
            if (sgn && v >= 128) return v + 32'hFFFF_FF00;
            return v;
        end
        v = sh % 65536;
        if (sgn && v >= 32768) return v + 32'hFFFF_0000;
        return v;
    endfunction

    function automatic bit exp_iq_full();
        int n = iq.size();
        foreach (tq[i]) if (tq[i].owner && !tq[i].disc) n++;
        return n >= IQD;
    endfunction

    function automatic logic [15:0] exp_instr();
        return (iq.size() > 0) ? iq[0] : 16'h0;
    endfunction

    task automatic model_reset();
        tq.delete();
        iq.delete();
        m_err = 0; m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    endtask

    task automatic model_step();
        bit full = (tq.size() == TGD);
        bit pop  = mem_output_valid_in && (tq.size() > 0);
        bit acc  = read_issue_in && (!full || pop);
        bit deq  = (iq.size() > 0) && instr_ready_in;
        bit push = 0;
        logic [15:0] pd = '0;
        tag_t t, n;
        m_wr_en = 0;
        if (mem_output_valid_in && tq.size() == 0) m_err = 1;
        if (pop) begin
            t = tq.pop_front();
            if (t.owner) begin
                if (!t.disc && !flush_in) begin
                    if (iq.size() == IQD && !deq) m_err = 1;
                    else begin
                        push = 1;
                        pd = t.ws ? mem_data_in[31:16] : mem_data_in[15:0];
                    end
                end
            end else begin
                m_wr_en   = 1;
                m_wr_addr = t.dest;
                m_wr_data = load_value(mem_data_in, t.lsb, t.size, t.sgn);
            end
        end
        if (deq) void'(iq.pop_front());
        if (push) iq.push_back(pd);
        if (flush_in) begin
            iq.delete();
            foreach (tq[i]) if (tq[i].owner) tq[i].disc = 1;
        end
        if (acc) begin
            n.owner = read_en_sel_in; n.ws = word_select_in; n.lsb = addr_lsb_in;
            n.size = load_size_in; n.sgn = load_signed_in; n.dest = load_dest_in; n.disc = 0;
            tq.push_back(n);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        read_issue_in = 0; read_en_sel_in = 0; word_select_in = 0;
        addr_lsb_in = '0; load_size_in = '0; load_signed_in = 0; load_dest_in = '0;
        flush_in = 0; mem_data_in = '0; mem_output_valid_in = 0; instr_ready_in = 0;
    endtask

    task automatic set_issue(bit owner, bit ws, bit [1:0] lsb, bit [1:0] size, bit sgn, bit [3:0] dest);
        read_issue_in = 1; read_en_sel_in = owner; word_select_in = ws;
        addr_lsb_in = lsb; load_size_in = size; load_signed_in = sgn; load_dest_in = dest;
    endtask

    task automatic set_return(logic [31:0] d);
        mem_output_valid_in = 1; mem_data_in = d;
    endtask

    // Apply current inputs for one clock edge; outputs are sampled 1ns after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (instr_out !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_out); end
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_out); end
        checks++; if (tag_full_out !== 1'b0) begin errors++; $display("FAIL reset_tag_full: got %b want 0", tag_full_out); end
        checks++; if (iq_full_out !== 1'b0) begin errors++; $display("FAIL reset_iq_full: got %b want 0", iq_full_out); end
        checks++; if (load_wr_en_out !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", load_wr_en_out); end
        checks++; if (load_wr_addr_out !== 4'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", load_wr_addr_out); end
        checks++; if (load_wr_data_out !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", load_wr_data_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error_out); end
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        set_issue(1, 1, 2'd0, 2'd0, 0, 4'd0);
        tick();
        checks++; if (tag_full_out !== 1'b0) begin errors++; $display("FAIL fetch_tag_full: got %b want 0", tag_full_out); end
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b want 0", instr_valid_out); end
        set_return(32'hABCD_1234);
        tick();
        checks++; if (instr_valid_out !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", instr_valid_out); end
        checks++; if (instr_out !== 16'hABCD) begin errors++; $display("FAIL fetch_instr: got %h want abcd", instr_out); end
        instr_ready_in = 1;
        tick();
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL fetch_drain: got %b want 0", instr_valid_out); end
    endtask

    task automatic test_load_byte();
        set_issue(0, 0, 2'd2, 2'd0, 1, 4'd5);
        tick();
        set_return(32'h0080_0000);
        tick();
        checks++; if (load_wr_en_out !== 1'b1) begin errors++; $display("FAIL sbyte_wr_en: got %b want 1", load_wr_en_out); end
        checks++; if (load_wr_data_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte_data: got %h want ffffff80", load_wr_data_out); end
        checks++; if (load_wr_addr_out !== 4'd5) begin errors++; $display("FAIL sbyte_addr: got %h want 5", load_wr_addr_out); end
        tick();
        checks++; if (load_wr_en_out !== 1'b0) begin errors++; $display("FAIL sbyte_pulse: got %b want 0", load_wr_en_out); end
        set_issue(0, 0, 2'd2, 2'd0, 0, 4'd6);
        tick();
        set_return(32'h0080_0000);
        tick();
        checks++; if (load_wr_data_out !== 32'h0000_0080) begin errors++; $display("FAIL ubyte_data: got %h want 00000080", load_wr_data_out); end
        checks++; if (load_wr_addr_out !== 4'd6) begin errors++; $display("FAIL ubyte_addr: got %h want 6", load_wr_addr_out); end
    endtask

    task automatic test_tag_full();
        set_issue(0, 0, 2'd0, 2'd2, 0, 4'd1);
        tick();
        set_issue(0, 0, 2'd0, 2'd2, 0, 4'd2);
        tick();
        checks++; if (tag_full_out !== 1'b1) begin errors++; $display("FAIL full_two: got %b want 1", tag_full_out); end
        set_issue(0, 0, 2'd0, 2'd2, 0, 4'd3);   // ignored: FIFO full, no return
        tick();
        checks++; if (tag_full_out !== 1'b1) begin errors++; $display("FAIL full_ignored: got %b want 1", tag_full_out); end
        set_issue(0, 0, 2'd1, 2'd2, 0, 4'd4);   // issue + return together
        set_return(32'h1111_1111);
        tick();
        checks++; if (tag_full_out !== 1'b1) begin errors++; $display("FAIL full_swap: got %b want 1", tag_full_out); end
        checks++; if (load_wr_addr_out !== 4'd1) begin errors++; $display("FAIL full_ret1_addr: got %h want 1", load_wr_addr_out); end
        set_return(32'h2222_2222);
        tick();
        checks++; if (load_wr_addr_out !== 4'd2) begin errors++; $display("FAIL full_ret2_addr: got %h want 2", load_wr_addr_out); end
        checks++; if (tag_full_out !== 1'b0) begin errors++; $display("FAIL full_release: got %b want 0", tag_full_out); end
        set_return(32'h3333_3333);
        tick();
        checks++; if (load_wr_addr_out !== 4'd4) begin errors++; $display("FAIL full_ret3_addr: got %h want 4", load_wr_addr_out); end
        checks++; if (load_wr_data_out !== 32'h3333_3333) begin errors++; $display("FAIL full_word_data: got %h want 33333333", load_wr_data_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL full_error: got %b want 0", error_out); end
    endtask

    task automatic test_flush();
        set_issue(1, 0, 2'd0, 2'd0, 0, 4'd0);
        tick();
        set_issue(1, 1, 2'd0, 2'd0, 0, 4'd0);
        tick();
        checks++; if (iq_full_out !== 1'b1) begin errors++; $display("FAIL flush_iq_full: got %b want 1", iq_full_out); end
        flush_in = 1;
        tick();
        checks++; if (iq_full_out !== 1'b0) begin errors++; $display("FAIL flush_release: got %b want 0", iq_full_out); end
        set_return(32'hDEAD_BEEF);
        tick();
        set_return(32'hCAFE_F00D);
        tick();
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", instr_valid_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL flush_error: got %b want 0", error_out); end
        set_issue(1, 0, 2'd0, 2'd0, 0, 4'd0);
        tick();
        set_return(32'h1111_2222);
        tick();
        checks++; if (instr_valid_out !== 1'b1) begin errors++; $display("FAIL flush_next_valid: got %b want 1", instr_valid_out); end
        checks++; if (instr_out !== 16'h2222) begin errors++; $display("FAIL flush_next_instr: got %h want 2222", instr_out); end
        instr_ready_in = 1;
        tick();
    endtask

    task automatic test_errors();
        set_return(32'h5555_5555);
        tick();
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL orphan_error: got %b want 1", error_out); end
        repeat (3) tick();
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", error_out); end
        do_reset();
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL error_cleared: got %b want 0", error_out); end
        set_issue(1, 0, 2'd0, 2'd0, 0, 4'd0);
        tick();
        set_return(32'h0000_AAAA);
        tick();
        set_issue(1, 0, 2'd0, 2'd0, 0, 4'd0);
        tick();
        set_return(32'h0000_BBBB);
        tick();
        checks++; if (iq_full_out !== 1'b1) begin errors++; $display("FAIL ovf_iq_full: got %b want 1", iq_full_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL ovf_pre_error: got %b want 0", error_out); end
        set_issue(1, 0, 2'd0, 2'd0, 0, 4'd0);
        tick();
        set_return(32'h0000_CCCC);
        tick();
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b want 1", error_out); end
        checks++; if (instr_out !== 16'hAAAA) begin errors++; $display("FAIL ovf_head: got %h want aaaa", instr_out); end
        instr_ready_in = 1;
        tick();
        checks++; if (instr_out !== 16'hBBBB) begin errors++; $display("FAIL ovf_second: got %h want bbbb", instr_out); end
        instr_ready_in = 1;
        tick();
        checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %b want 0", instr_valid_out); end
    endtask

    task automatic test_random();
        bit owner;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            owner = 1'($urandom % 2);
            if (owner && exp_iq_full()) owner = 0;
            if ($urandom % 2)
                set_issue(owner, 1'($urandom % 2), 2'($urandom % 4), 2'($urandom % 4),
                          1'($urandom % 2), 4'($urandom % 16));
            if (tq.size() > 0 && ($urandom % 2)) set_return($urandom);
            flush_in       = ($urandom % 12) == 0;
            instr_ready_in = 1'($urandom % 2);
            tick();
            checks++; if (tag_full_out !== (tq.size() == TGD)) begin errors++; $display("FAIL rnd_tag_full c=%0d: got %b want %b", c, tag_full_out, tq.size() == TGD); end
            checks++; if (iq_full_out !== exp_iq_full()) begin errors++; $display("FAIL rnd_iq_full c=%0d: got %b want %b", c, iq_full_out, exp_iq_full()); end
            checks++; if (instr_valid_out !== (iq.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, instr_valid_out, iq.size() > 0); end
            checks++; if (instr_out !== exp_instr()) begin errors++; $display("FAIL rnd_instr c=%0d: got %h want %h", c, instr_out, exp_instr()); end
            checks++; if (load_wr_en_out !== m_wr_en) begin errors++; $display("FAIL rnd_wr_en c=%0d: got %b want %b", c, load_wr_en_out, m_wr_en); end
            if (m_wr_en) begin
                checks++; if (load_wr_addr_out !== m_wr_addr) begin errors++; $display("FAIL rnd_wr_addr c=%0d: got %h want %h", c, load_wr_addr_out, m_wr_addr); end
                checks++; if (load_wr_data_out !== m_wr_data) begin errors++; $display("FAIL rnd_wr_data c=%0d: got %h want %h", c, load_wr_data_out, m_wr_data); end
            end
            checks++; if (error_out !== m_err) begin errors++; $display("FAIL rnd_error c=%0d: got %b want %b", c, error_out, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_byte();
        test_tag_full();
        test_flush();
        test_errors();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
